// File: rtl/panel_pkg.sv
// panel_pkg: shared constants for panel_io (default timing counts, blank code, hex glyph table)
//   DEB_CNT_DEF  : default debounce length in cycles (10 ms at 100 MHz)
//   SCAN_CNT_DEF : default per-digit scan time in cycles (1 ms at 100 MHz)
//   SEG_BLANK    : active-low segment code with every segment and dp dark
//   HEX_SEG      : active-low glyphs for 0..F, entry n is the glyph of nibble n
//   hex_glyph()  : nibble -> full 8-bit ca_n code with dp forced dark
package panel_pkg;

    localparam int DEB_CNT_DEF  = 1000000;
    localparam int SCAN_CNT_DEF = 100000;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef logic [1:0] digit_t;

    localparam logic [15:0][7:0] HEX_SEG = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic [7:0] hex_glyph(input logic [3:0] nib);
        return {1'b1, HEX_SEG[nib][6:0]};
    endfunction

endpackage

// File: rtl/panel_io_if.sv
// panel_io_if: board-facing and CPU-facing signals of the panel I/O block
//   sw_pad, btn_pad   : raw asynchronous switches / buttons from the board
//   seg_val           : four hex nibbles from the CPU to display
//   sw_out            : synchronized switches to the CPU
//   btn_out, btn_pulse: debounced button levels and their rising-edge strobes
//   an_n, ca_n        : active-low digit enables and segment drives
//   master            : the side producing pads/seg_val (board + CPU, or a bench)
//   slave             : panel_io itself
interface panel_io_if;

    logic [7:0]  sw_pad;
    logic [3:0]  btn_pad;
    logic [15:0] seg_val;
    logic [7:0]  sw_out;
    logic [3:0]  btn_out;
    logic [3:0]  btn_pulse;
    logic [3:0]  an_n;
    logic [7:0]  ca_n;

    modport master (
        output sw_pad, btn_pad, seg_val,
        input  sw_out, btn_out, btn_pulse, an_n, ca_n
    );

    modport slave (
        input  sw_pad, btn_pad, seg_val,
        output sw_out, btn_out, btn_pulse, an_n, ca_n
    );

endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: one button channel -- two-flop synchronizer, debounce counter, stable level, rise strobe
//   clk, rst_n : clock and asynchronous active-low reset
//   btn_i      : raw asynchronous button pad
//   level_o    : debounced stable level
//   pulse_o    : one-cycle strobe coincident with level_o rising
module btn_debounce #(
    parameter int DEB_CNT = panel_pkg::DEB_CNT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o,
    output logic pulse_o
);

    localparam int CW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;

    logic          s1_q, s2_q;
    logic          stable_q, stable_d;
    logic          pulse_q, pulse_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          differ, accept;

    always_comb begin
        differ   = s2_q != stable_q;
        accept   = differ && cnt_q == CW'(DEB_CNT - 1);
        // any return to the stable level restarts the count from zero
        cnt_d    = (!differ || accept) ? '0 : cnt_q + CW'(1);
        stable_d = accept ? ~stable_q : stable_q;
        pulse_d  = accept && !stable_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            s1_q     <= btn_i;
            s2_q     <= s1_q;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            pulse_q  <= pulse_d;
        end
    end

    assign level_o = stable_q;
    assign pulse_o = pulse_q;

endmodule

// File: rtl/panel_io.sv
// panel_io: switch synchronizer, 4-channel button debouncer and 4-digit multiplexed 7-segment driver
//   clk, rst_n : clock and asynchronous active-low reset
//   io         : panel_io_if slave -- pads and seg_val in; sw_out, btn_out, btn_pulse, an_n, ca_n out
module panel_io
    import panel_pkg::*;
#(
    parameter int DEB_CNT  = DEB_CNT_DEF,
    parameter int SCAN_CNT = SCAN_CNT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    panel_io_if.slave  io
);

    localparam int PW = (SCAN_CNT > 1) ? $clog2(SCAN_CNT) : 1;

    logic [7:0]    sw_s1_q, sw_s2_q;
    logic [3:0]    btn_lvl, btn_pls;
    logic [PW-1:0] pre_q, pre_d;
    digit_t        idx_q, idx_d;
    logic [15:0]   snap_q, snap_d;
    logic [3:0]    an_q, an_d;
    logic [7:0]    ca_q, ca_d;
    logic          tc;

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb (
            .clk     (clk),
            .rst_n   (rst_n),
            .btn_i   (io.btn_pad[i]),
            .level_o (btn_lvl[i]),
            .pulse_o (btn_pls[i])
        );
    end

    always_comb begin
        tc     = pre_q == PW'(SCAN_CNT - 1);
        pre_d  = tc ? '0 : pre_q + PW'(1);
        idx_d  = tc ? idx_q + 2'd1 : idx_q;
        // snapshot only at the end of digit 3 so a frame is never a mix of two seg_val values
        snap_d = (tc && idx_q == 2'd3) ? io.seg_val : snap_q;
        an_d   = ~(4'b0001 << idx_q);
        ca_d   = hex_glyph(snap_q[{idx_q, 2'b00} +: 4]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_s1_q <= '0;
            sw_s2_q <= '0;
            pre_q   <= '0;
            idx_q   <= '0;
            snap_q  <= '0;
            an_q    <= 4'hF;
            ca_q    <= SEG_BLANK;
        end else begin
            sw_s1_q <= io.sw_pad;
            sw_s2_q <= sw_s1_q;
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            an_q    <= an_d;
            ca_q    <= ca_d;
        end
    end

    assign io.sw_out    = sw_s2_q;
    assign io.btn_out   = btn_lvl;
    assign io.btn_pulse = btn_pls;
    assign io.an_n      = an_q;
    assign io.ca_n      = ca_q;

endmodule

// File: tb/tb_panel_io.sv
// tb_panel_io: directed self-checking bench for panel_io with DEB_CNT=4, SCAN_CNT=3
module tb_panel_io;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   errors = 0;

    localparam logic [3:0] AN_EXP [4]    = '{4'hE, 4'hD, 4'hB, 4'h7};
    localparam logic [7:0] GLYPH_12F0 [4] = '{8'hC0, 8'h8E, 8'hA4, 8'hF9};

    panel_io_if io();

    panel_io #(.DEB_CNT(4), .SCAN_CNT(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        io.sw_pad  = 8'h00;
        io.btn_pad = 4'h0;
        io.seg_val = 16'h0000;
        rst_n = 1'b0;
        #12;
        vectors++; if (io.an_n !== 4'hF) begin errors++; $display("FAIL reset an_n got %h exp F", io.an_n); end
        vectors++; if (io.ca_n !== 8'hFF) begin errors++; $display("FAIL reset ca_n got %h exp FF", io.ca_n); end
        vectors++; if (io.sw_out !== 8'h00) begin errors++; $display("FAIL reset sw_out got %h exp 00", io.sw_out); end
        vectors++; if (io.btn_out !== 4'h0) begin errors++; $display("FAIL reset btn_out got %h exp 0", io.btn_out); end
        vectors++; if (io.btn_pulse !== 4'h0) begin errors++; $display("FAIL reset btn_pulse got %h exp 0", io.btn_pulse); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        vectors++; if (io.an_n !== 4'hE) begin errors++; $display("FAIL release an_n got %h exp E", io.an_n); end
        vectors++; if (io.ca_n !== 8'hC0) begin errors++; $display("FAIL release ca_n got %h exp C0", io.ca_n); end
        io.sw_pad = 8'hFF;
        repeat (4) step();
        vectors++; if (io.sw_out !== 8'hFF) begin errors++; $display("FAIL pre-reset sw_out got %h exp FF", io.sw_out); end
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        vectors++; if (io.an_n !== 4'hF) begin errors++; $display("FAIL async reset an_n got %h exp F", io.an_n); end
        vectors++; if (io.ca_n !== 8'hFF) begin errors++; $display("FAIL async reset ca_n got %h exp FF", io.ca_n); end
        vectors++; if (io.sw_out !== 8'h00) begin errors++; $display("FAIL async reset sw_out got %h exp 00", io.sw_out); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        vectors++; if (io.an_n !== 4'hE) begin errors++; $display("FAIL re-release an_n got %h exp E", io.an_n); end
        vectors++; if (io.ca_n !== 8'hC0) begin errors++; $display("FAIL re-release ca_n got %h exp C0", io.ca_n); end
        io.sw_pad = 8'h00;
    endtask

    task automatic test_sw;
        repeat (3) step();
        io.sw_pad = 8'hA5;
        step();
        vectors++; if (io.sw_out !== 8'h00) begin errors++; $display("FAIL sw edge1 got %h exp 00", io.sw_out); end
        step();
        vectors++; if (io.sw_out !== 8'hA5) begin errors++; $display("FAIL sw edge2 got %h exp A5", io.sw_out); end
        io.sw_pad = 8'h3C;
        step();
        vectors++; if (io.sw_out !== 8'hA5) begin errors++; $display("FAIL sw hold got %h exp A5", io.sw_out); end
        step();
        vectors++; if (io.sw_out !== 8'h3C) begin errors++; $display("FAIL sw second got %h exp 3C", io.sw_out); end
    endtask

    // after reset the snapshot is 0000 for edges 1..12, then 12F0 from edge 13
    task automatic test_display;
        io.seg_val = 16'h12F0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 24; e++) begin
            int d;
            logic [7:0] exp_ca;
            step();
            d = ((e - 1) / 3) % 4;
            exp_ca = (e <= 12) ? 8'hC0 : GLYPH_12F0[d];
            vectors++; if (io.an_n !== AN_EXP[d]) begin errors++; $display("FAIL display an_n e=%0d got %h exp %h", e, io.an_n, AN_EXP[d]); end
            vectors++; if (io.ca_n !== exp_ca) begin errors++; $display("FAIL display ca_n e=%0d got %h exp %h", e, io.ca_n, exp_ca); end
        end
    endtask

    // continues the frame sequence of test_display: seg_val changes while digit 1 is shown
    task automatic test_frame_swap;
        for (int e = 25; e <= 48; e++) begin
            int d;
            logic [7:0] exp_ca;
            step();
            d = ((e - 1) / 3) % 4;
            exp_ca = (e <= 36) ? GLYPH_12F0[d] : 8'h8E;
            vectors++; if (io.an_n !== AN_EXP[d]) begin errors++; $display("FAIL swap an_n e=%0d got %h exp %h", e, io.an_n, AN_EXP[d]); end
            vectors++; if (io.ca_n !== exp_ca) begin errors++; $display("FAIL swap ca_n e=%0d got %h exp %h", e, io.ca_n, exp_ca); end
            if (e == 28) io.seg_val = 16'hFFFF;
        end
    endtask

    task automatic test_btn_glitch;
        io.btn_pad = 4'b0001;
        for (int e = 1; e <= 11; e++) begin
            step();
            vectors++; if (io.btn_out !== 4'h0) begin errors++; $display("FAIL glitch btn_out e=%0d got %h exp 0", e, io.btn_out); end
            vectors++; if (io.btn_pulse !== 4'h0) begin errors++; $display("FAIL glitch btn_pulse e=%0d got %h exp 0", e, io.btn_pulse); end
            if (e == 3) io.btn_pad = 4'b0000;
        end
    endtask

    task automatic test_btn_press;
        io.btn_pad = 4'b0001;
        for (int e = 1; e <= 8; e++) begin
            logic [3:0] eo, ep;
            step();
            eo = (e >= 6) ? 4'b0001 : 4'b0000;
            ep = (e == 6) ? 4'b0001 : 4'b0000;
            vectors++; if (io.btn_out !== eo) begin errors++; $display("FAIL press btn_out e=%0d got %h exp %h", e, io.btn_out, eo); end
            vectors++; if (io.btn_pulse !== ep) begin errors++; $display("FAIL press btn_pulse e=%0d got %h exp %h", e, io.btn_pulse, ep); end
        end
        io.btn_pad = 4'b0000;
        for (int e = 1; e <= 8; e++) begin
            logic [3:0] eo;
            step();
            eo = (e < 6) ? 4'b0001 : 4'b0000;
            vectors++; if (io.btn_out !== eo) begin errors++; $display("FAIL release btn_out e=%0d got %h exp %h", e, io.btn_out, eo); end
            vectors++; if (io.btn_pulse !== 4'h0) begin errors++; $display("FAIL release btn_pulse e=%0d got %h exp 0", e, io.btn_pulse); end
        end
    endtask

    // bits 1 and 3 pressed together, bit 2 two cycles later
    task automatic test_btn_multi;
        io.btn_pad = 4'b1010;
        for (int e = 1; e <= 10; e++) begin
            logic [3:0] eo, ep;
            step();
            eo = (e < 6) ? 4'b0000 : (e < 8) ? 4'b1010 : 4'b1110;
            ep = (e == 6) ? 4'b1010 : (e == 8) ? 4'b0100 : 4'b0000;
            vectors++; if (io.btn_out !== eo) begin errors++; $display("FAIL multi btn_out e=%0d got %h exp %h", e, io.btn_out, eo); end
            vectors++; if (io.btn_pulse !== ep) begin errors++; $display("FAIL multi btn_pulse e=%0d got %h exp %h", e, io.btn_pulse, ep); end
            if (e == 2) io.btn_pad = 4'b1110;
        end
    endtask

    task automatic test_reset_mid_debounce;
        io.btn_pad = 4'b1111;
        repeat (4) step();
        @(negedge clk);
        rst_n = 1'b0;
        io.btn_pad = 4'b0000;
        #1;
        vectors++; if (io.btn_out !== 4'h0) begin errors++; $display("FAIL mid reset btn_out got %h exp 0", io.btn_out); end
        vectors++; if (io.btn_pulse !== 4'h0) begin errors++; $display("FAIL mid reset btn_pulse got %h exp 0", io.btn_pulse); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            vectors++; if (io.btn_out !== 4'h0) begin errors++; $display("FAIL post reset btn_out e=%0d got %h exp 0", e, io.btn_out); end
            vectors++; if (io.btn_pulse !== 4'h0) begin errors++; $display("FAIL post reset btn_pulse e=%0d got %h exp 0", e, io.btn_pulse); end
        end
    endtask

    initial begin
        test_reset();
        test_sw();
        test_display();
        test_frame_swap();
        test_btn_glitch();
        test_btn_press();
        test_btn_multi();
        test_reset_mid_debounce();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
